uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised oversampling UART receiver: next generation of the fixed 8N1/16x receiver.
//  Adds configurable data width, parity, stop bits and oversample ratio, a 3-sample majority vote,
//  per-word error flags, break detection and a valid/ready output handshake with overrun flagging.
//  Sits between the RXD pad and the command/FIFO logic; one instance per serial channel.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, LSB first
//  OVERSAMPLE  16  sample_en ticks per bit, even, legal 8..32
//  PARITY_EN   0   1 = parity bit follows the data bits
//  PARITY_ODD  0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  STOP_BITS   1   stop bits checked, 1 or 2
// PORTS
//  rx_clk         in   1          system clock, all logic on posedge
//  reset          in   1          asynchronous, active-high reset
//  sample_en      in   1          oversample strobe, 1 rx_clk wide, OVERSAMPLE per bit period
//  rxd            in   1          serial input, asynchronous, idle high
//  rx_data        out  DATA_BITS  received word, valid while rx_valid=1
//  rx_parity_err  out  1          parity mismatch for the word in rx_data
//  rx_frame_err   out  1          a stop bit sampled 0 for the word in rx_data
//  rx_break       out  1          word is a break: all data bits, parity (if any) and stop sampled 0
//  rx_valid       out  1          holding register full
//  rx_ready       in   1          consumer accepts word when rx_valid & rx_ready
//  overrun        out  1          sticky: a completed word was dropped because holding reg was full
//  err_clr        in   1          1-cycle pulse clears overrun
//  busy           out  1          1 whenever state != IDLE
// BEHAVIOUR
//  - rxd passes through a 2-FF synchroniser (reset to 1); a 3-bit shift reg of synchronised rxd
//    is loaded on each sample_en. Everything except the handshake advances only on sample_en.
//  - Bit vote = majority of the last 3 samples, taken at tick cnt==OVERSAMPLE/2+1 of each bit.
//  - cnt: $clog2(OVERSAMPLE) bits, counts 0..OVERSAMPLE-1 per bit, wraps to 0 at bit boundary.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE: synced sample 0 with previous sample 1 -> START, cnt=0 (edge tick is cnt 0).
//    START: vote=1 -> IDLE (false start, nothing reported); vote=0 -> continue, DATA at wrap.
//    DATA: DATA_BITS bits shifted in LSB first; then PARITY if PARITY_EN else STOP.
//    PARITY: vote compared with XOR(data)^PARITY_ODD; mismatch sets the word's parity_err.
//    STOP: STOP_BITS bits; any vote=0 sets frame_err. At the vote of the LAST stop bit the word
//      is completed and FSM goes straight to IDLE (no wait for stop-bit end), so a start edge in
//      the second half of the stop bit is caught.
//  - Completion: on the rx_clk edge of the completing sample_en, word+flags load into the holding
//    register and rx_valid=1 (latency 1 rx_clk after that tick). break = data all 0, parity (if
//    any) 0 and frame_err=1; a break word is delivered with frame_err=1 and rx_break=1.
//  - Handshake: rx_valid stays 1, rx_data/flags stable until rx_valid&rx_ready; then rx_valid=0
//    next cycle. rx_ready ignored while rx_valid=0.
//  - Completion while rx_valid=1 and rx_ready=0: new word dropped, old word kept, overrun=1.
//    Completion in the same cycle as rx_valid&rx_ready: old word consumed, new word loaded,
//    rx_valid stays 1, no overrun.
//  - err_clr clears overrun; err_clr in the same cycle as a new overrun event: overrun stays 1.
//  - No receiver timeout: the FSM advances only on sample_en; sample_en stuck low freezes it.
//  - Reset (any time, incl. mid-frame): FSM IDLE, cnt 0, synchroniser and sample reg all 1;
//    rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_break=0, rx_valid=0, overrun=0, busy=0.
//    A partially received frame is discarded.
// TESTING
//  1 Defaults, 8N1, 0xA5 sent -> rx_valid=1, rx_data=8'hA5, all error flags 0, 1 cycle after
//    the stop-bit vote tick.
//  2 rxd low for 4 ticks then high -> START rejects, busy returns 0, rx_valid never asserts.
//  3 PARITY_EN=1 even, send 0x03 with parity bit 1 -> rx_data=8'h03, rx_parity_err=1;
//    with parity bit 0 -> rx_parity_err=0.
//  4 Send 0x00 with stop bit 0 -> rx_frame_err=1, rx_break=1; send 0x55 with stop 0
//    -> rx_frame_err=1, rx_break=0.
//  5 rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 8'h11, overrun=1;
//    err_clr pulse -> overrun=0; rx_ready pulsed on the completion cycle -> 0x22 loaded, no overrun.
//  6 Assert reset mid-data-bit 4 -> all outputs 0, busy=0; next clean frame 0x3C received
//    correctly; also run DATA_BITS=7, OVERSAMPLE=8, STOP_BITS=2 with 0x7F.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable frame format, 3-sample majority vote,
// per-word error/break flags and a valid/ready holding register with sticky overrun.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 rx_clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] VOTE_IDX  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, curIdx;
  logic [3:0]           bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, parVal_q, parVal_d;
  logic                 sync1_q, sync2_q;
  logic [2:0]           samp_q;
  logic                 vote, atVote, atLast, complete, compFerr, compBrk, consume;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 hPerr_q, hPerr_d, hFerr_q, hFerr_d, hBrk_q, hBrk_d;
  logic                 valid_q, valid_d, ovr_q, ovr_d;

  assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign curIdx   = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
  assign atVote   = (curIdx == VOTE_IDX);
  assign atLast   = (curIdx == LAST_IDX);
  assign compFerr = ferr_q | ~vote;
  assign compBrk  = (shift_q == '0) && ((PARITY_EN == 0) || !parVal_q) && compFerr;
  assign consume  = valid_q & rx_ready;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      samp_q  <= 3'b111;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      if (sample_en) samp_q <= {samp_q[1:0], sync2_q};
    end
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      parVal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      parVal_q <= parVal_d;
    end
  end

  // The falling-edge tick is tick 0 of the start bit; all later ticks index within a bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    parVal_d = parVal_q;
    complete = 1'b0;
    if (sample_en) begin
      if (state_q == IDLE) begin
        if (!sync2_q && samp_q[0]) begin
          state_d  = START;
          cnt_d    = '0;
          bitCnt_d = '0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
          parVal_d = 1'b0;
        end
      end else begin
        cnt_d = curIdx;
        case (state_q)
          START: begin
            if (atVote && vote) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (atLast) begin
              state_d = DATA;
            end
          end
          DATA: begin
            if (atVote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
            if (atLast) begin
              if (bitCnt_q == LAST_DATA) begin
                bitCnt_d = '0;
                state_d  = (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bitCnt_d = bitCnt_q + 4'd1;
              end
            end
          end
          PARITY: begin
            if (atVote) begin
              parVal_d = vote;
              perr_d   = vote != (^shift_q ^ ODD_BIT);
            end
            if (atLast) state_d = STOP;
          end
          STOP: begin
            if (atVote) begin
              ferr_d = compFerr;
              if (bitCnt_q == LAST_STOP) begin
                complete = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
              end
            end else if (atLast) begin
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // A word completing while the consumer drains the old one replaces it without overrun.
  always_comb begin
    data_d  = data_q;
    hPerr_d = hPerr_q;
    hFerr_d = hFerr_q;
    hBrk_d  = hBrk_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete && (!valid_q || consume)) begin
      data_d  = shift_q;
      hPerr_d = perr_q;
      hFerr_d = compFerr;
      hBrk_d  = compBrk;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
    if (complete && valid_q && !consume) ovr_d = 1'b1;
    else if (err_clr)                    ovr_d = 1'b0;
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      hPerr_q <= 1'b0;
      hFerr_q <= 1'b0;
      hBrk_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      hPerr_q <= hPerr_d;
      hFerr_q <= hFerr_d;
      hBrk_q  <= hBrk_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_parity_err = hPerr_q;
  assign rx_frame_err  = hFerr_q;
  assign rx_break      = hBrk_q;
  assign rx_valid      = valid_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != IDLE);

endmodule
